// File: rtl/dcacheread_responder_if.sv
// dcacheread_responder_if: read-link and memory-burst signals between requester/memory and the responder
//   slave modport  : responder view (request in, done/data out, burst request out, burst beats in)
//   master modport : requester + memory view (mirror of slave)
//   dcacheread_*   : held read request, one-cycle done pulse, 64-bit right-aligned data
//   dcache_invalidate : pulse clearing every valid bit
//   readburst_*    : line burst request, 4 ascending dword beats, completion
interface dcacheread_responder_if;
  logic        dcacheread_do;
  logic        dcacheread_done;
  logic [3:0]  dcacheread_length;
  logic        dcacheread_cache_disable;
  logic [31:0] dcacheread_address;
  logic [63:0] dcacheread_data;
  logic        dcache_invalidate;
  logic        readburst_do;
  logic [31:0] readburst_address;
  logic        readburst_data_valid;
  logic [31:0] readburst_data;
  logic        readburst_done;
  modport slave (
    input  dcacheread_do, dcacheread_length, dcacheread_cache_disable, dcacheread_address,
    input  dcache_invalidate, readburst_data_valid, readburst_data, readburst_done,
    output dcacheread_done, dcacheread_data, readburst_do, readburst_address
  );
  modport master (
    output dcacheread_do, dcacheread_length, dcacheread_cache_disable, dcacheread_address,
    output dcache_invalidate, readburst_data_valid, readburst_data, readburst_done,
    input  dcacheread_done, dcacheread_data, readburst_do, readburst_address
  );
endinterface

// File: rtl/dcacheread_responder.sv
// dcacheread_responder: serves held read requests from a direct-mapped line cache or line bursts
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : dcacheread_responder_if.slave (request/done/data, invalidate, memory burst link)
//   LINES : number of 16-byte lines (power of two, 2..256)
module dcacheread_responder #(
  parameter int LINES = 16
) (
  input logic clk,
  input logic rst_n,
  dcacheread_responder_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0] len_q, len_d;
  logic cd_q, cd_d;
  logic line_q, line_d;
  logic inv_q, inv_d;
  logic [1:0] beat_q, beat_d;
  logic [63:0] asm_q, asm_d;
  logic [127:0] lbuf_q, lbuf_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [LINES];
  logic [127:0] line_mem [LINES];
  logic [31:0] cur_addr;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, more, fill_done, take;
  logic [127:0] fill_line, src;
  assign cur_addr = {addr_q[31:4], 4'b0} + (line_q ? 32'd16 : 32'd0);
  assign idx = cur_addr[4 +: IW];
  assign tag = cur_addr[31 -: TW];
  assign hit = valid_q[idx] && tag_q[idx] == tag && !cd_q;
  // a second line is needed only while still on the first and the access crosses byte 16
  assign more = !line_q && ({1'b0, addr_q[3:0]} + {1'b0, len_q} > 5'd16);
  assign fill_done = state_q == FILL && bus.readburst_done;
  assign take = (state_q == LOOKUP && hit) || fill_done;
  assign src = state_q == FILL ? fill_line : line_mem[idx];
  // the last beat may coincide with readburst_done, so merge it combinationally
  always_comb begin
    fill_line = lbuf_q;
    if (bus.readburst_data_valid) fill_line[{beat_q, 5'b0} +: 32] = bus.readburst_data;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.dcacheread_do ? LOOKUP : IDLE;
      LOOKUP:  state_d = len_q == 4'd0 ? DONE : !hit ? FILL : more ? LOOKUP : DONE;
      FILL:    state_d = !bus.readburst_done ? FILL : more ? LOOKUP : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    logic [4:0] off;
    off = '0;
    addr_d = addr_q;
    len_d = len_q;
    cd_d = cd_q;
    line_d = line_q;
    asm_d = asm_q;
    beat_d = beat_q;
    lbuf_d = lbuf_q;
    inv_d = inv_q | bus.dcache_invalidate;
    valid_d = bus.dcache_invalidate ? '0 : valid_q;
    if (state_q == IDLE && bus.dcacheread_do) begin
      addr_d = bus.dcacheread_address;
      len_d = bus.dcacheread_length > 4'd8 ? 4'd8 : bus.dcacheread_length;
      cd_d = bus.dcacheread_cache_disable;
      line_d = 1'b0;
      asm_d = '0;
    end
    if (state_q == LOOKUP && state_d == FILL) begin
      beat_d = '0;
      inv_d = 1'b0;
    end
    if (state_q == FILL && bus.readburst_data_valid) begin
      lbuf_d = fill_line;
      beat_d = beat_q + 2'd1;
    end
    // byte k of the result comes from line offset addr[3:0]+k; bit 4 of that sum selects the line
    if (take) begin
      for (int k = 0; k < 8; k++) begin
        off = {1'b0, addr_q[3:0]} + 5'(k);
        if (4'(k) < len_q && off[4] == line_q) asm_d[8*k +: 8] = src[{off[3:0], 3'b0} +: 8];
      end
    end
    if (take && more) line_d = 1'b1;
    // an invalidate seen during this fill leaves the freshly written line invalid
    if (fill_done && !cd_q && !inv_q && !bus.dcache_invalidate) valid_d[idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      cd_q <= 1'b0;
      line_q <= 1'b0;
      inv_q <= 1'b0;
      beat_q <= '0;
      asm_q <= '0;
      lbuf_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cd_q <= cd_d;
      line_q <= line_d;
      inv_q <= inv_d;
      beat_q <= beat_d;
      asm_q <= asm_d;
      lbuf_q <= lbuf_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill_done && !cd_q) begin
      tag_q[idx] <= tag;
      line_mem[idx] <= fill_line;
    end
  end
  always_comb begin
    bus.dcacheread_done = state_q == DONE;
    bus.dcacheread_data = state_q == DONE ? asm_q : '0;
    bus.readburst_do = state_q == FILL;
    bus.readburst_address = state_q == FILL ? cur_addr : '0;
  end
endmodule

// File: tb/tb_dcacheread_responder.sv
// tb_dcacheread_responder: directed and random reads against a cache/memory reference model
module tb_dcacheread_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dcacheread_responder_if bus();
  dcacheread_responder #(.LINES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] burst_log [$];
  logic [31:0] exp_bursts [$];
  bit rv [16];
  logic [23:0] rt [16];
  logic [7:0] rd [16][16];
  logic [7:0] lbytes [16];
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    foreach (rv[i]) rv[i] = 1'b0;
  endtask
  // reference cache: hit copies the cached bytes, miss reads memory and allocates unless bypassed
  task automatic model_line(input logic [31:0] la, input bit cd);
    int i;
    i = int'(la[7:4]);
    if (rv[i] && rt[i] == la[31:8] && !cd) begin
      for (int j = 0; j < 16; j++) lbytes[j] = rd[i][j];
    end else begin
      exp_bursts.push_back(la);
      for (int j = 0; j < 16; j++) lbytes[j] = 8'(mem_rd(la + 32'(j & 12)) >> (8 * (j % 4)));
      if (!cd) begin
        rv[i] = 1'b1;
        rt[i] = la[31:8];
        for (int j = 0; j < 16; j++) rd[i][j] = lbytes[j];
      end
    end
  endtask
  task automatic invalidate();
    @(posedge clk); #1;
    bus.dcache_invalidate = 1'b1;
    @(posedge clk); #1;
    bus.dcache_invalidate = 1'b0;
    model_clear();
  endtask
  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input bit cd, input bit inv_fill, input string tag);
    int el, off0, n;
    bit two, got, pulsed;
    logic [63:0] ed;
    logic [31:0] l0;
    el = len > 8 ? 8 : int'(len);
    off0 = int'(a[3:0]);
    two = off0 + el > 16;
    l0 = {a[31:4], 4'b0};
    ed = '0;
    exp_bursts.delete();
    if (el > 0) begin
      model_line(l0, cd);
      for (int i = 0; i < el; i++) if (off0 + i < 16) ed[8*i +: 8] = lbytes[off0 + i];
      if (two) begin
        model_line(l0 + 32'd16, cd);
        for (int i = 0; i < el; i++) if (off0 + i >= 16) ed[8*i +: 8] = lbytes[off0 + i - 16];
      end
    end
    if (inv_fill) model_clear();
    burst_log.delete();
    bus.dcacheread_address = a;
    bus.dcacheread_length = len;
    bus.dcacheread_cache_disable = cd;
    bus.dcacheread_do = 1'b1;
    got = 0;
    pulsed = 0;
    n = 0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (bus.dcache_invalidate) bus.dcache_invalidate = 1'b0;
      if (inv_fill && !pulsed && bus.readburst_do) begin
        bus.dcache_invalidate = 1'b1;
        pulsed = 1;
      end
      if (bus.dcacheread_done) got = 1;
    end
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " data"}, bus.dcacheread_data, ed);
    chk({tag, " rbdo_in_done"}, 64'(bus.readburst_do), 64'd0);
    chk({tag, " nburst"}, 64'(burst_log.size()), 64'(exp_bursts.size()));
    for (int i = 0; i < burst_log.size() && i < exp_bursts.size(); i++)
      chk({tag, " burst_addr"}, 64'(burst_log[i]), 64'(exp_bursts[i]));
    if (exp_bursts.size() == 0) chk({tag, " latency"}, 64'(n), two ? 64'd3 : 64'd2);
    bus.dcacheread_do = 1'b0;
    @(posedge clk); #1;
    chk({tag, " single_pulse"}, 64'(bus.dcacheread_done), 64'd0);
  endtask
  // memory: random start latency and beat gaps, done with or after the 4th beat
  initial begin
    int gap, beat;
    bit busy;
    logic [31:0] ma;
    gap = 0;
    beat = 0;
    busy = 0;
    ma = '0;
    bus.readburst_data_valid = 1'b0;
    bus.readburst_done = 1'b0;
    bus.readburst_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.readburst_data_valid = 1'b0;
      bus.readburst_done = 1'b0;
      if (!rst_n) busy = 0;
      else if (!busy) begin
        if (bus.readburst_do) begin
          busy = 1;
          beat = 0;
          ma = bus.readburst_address;
          burst_log.push_back(ma);
          gap = $urandom_range(0, 2);
        end
      end else if (gap > 0) gap--;
      else if (beat < 4) begin
        bus.readburst_data_valid = 1'b1;
        bus.readburst_data = mem_rd(ma + 32'(4 * beat));
        beat++;
        gap = $urandom_range(0, 1);
        if (beat == 4 && $urandom_range(0, 1) == 1) begin
          bus.readburst_done = 1'b1;
          busy = 0;
        end
      end else begin
        bus.readburst_done = 1'b1;
        busy = 0;
      end
    end
  end
  initial begin
    bit seen;
    int n;
    logic [31:0] a;
    bus.dcacheread_do = 1'b0;
    bus.dcacheread_length = '0;
    bus.dcacheread_cache_disable = 1'b0;
    bus.dcacheread_address = '0;
    bus.dcache_invalidate = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) mem[32'h1000 + 32'(4 * i)] = 32'h11111111 * 32'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", 64'(bus.dcacheread_done), 64'd0);
    chk("rst data", bus.dcacheread_data, 64'd0);
    chk("rst rbdo", 64'(bus.readburst_do), 64'd0);
    chk("rst rbaddr", 64'(bus.readburst_address), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    do_read(32'h00001004, 4'd4, 1'b0, 1'b0, "cold");
    do_read(32'h00001004, 4'd4, 1'b0, 1'b0, "hit");
    invalidate();
    do_read(32'h0000100E, 4'd8, 1'b0, 1'b0, "span");
    do_read(32'h0000100E, 4'd8, 1'b0, 1'b0, "span_hit");
    mem[32'h1004] = 32'hDEADBEEF;
    do_read(32'h00001004, 4'd4, 1'b1, 1'b0, "bypass");
    do_read(32'h00001004, 4'd4, 1'b0, 1'b0, "after_bypass");
    invalidate();
    do_read(32'h00001004, 4'd4, 1'b0, 1'b0, "inv_miss");
    do_read(32'h00002000, 4'd4, 1'b0, 1'b1, "inv_fill");
    do_read(32'h00002000, 4'd4, 1'b0, 1'b0, "inv_fill_reread");
    do_read(32'h00000000, 4'd4, 1'b0, 1'b0, "evict_a");
    do_read(32'h00000100, 4'd4, 1'b0, 1'b0, "evict_b");
    do_read(32'h00000000, 4'd4, 1'b0, 1'b0, "evict_a_again");
    do_read(32'h00001004, 4'd0, 1'b0, 1'b0, "len0");
    do_read(32'h00001003, 4'd15, 1'b0, 1'b0, "len15");
    do_read(32'hFFFFFFFC, 4'd8, 1'b0, 1'b0, "wrap");
    do_read(32'hFFFFFFFC, 4'd8, 1'b0, 1'b0, "wrap_hit");
    bus.dcacheread_address = 32'h00003000;
    bus.dcacheread_length = 4'd4;
    bus.dcacheread_cache_disable = 1'b0;
    bus.dcacheread_do = 1'b1;
    seen = 0;
    n = 0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (bus.readburst_do) seen = 1;
    end
    chk("rst_fill burst_seen", 64'(seen), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_fill rbdo", 64'(bus.readburst_do), 64'd0);
    chk("rst_fill done", 64'(bus.dcacheread_done), 64'd0);
    chk("rst_fill rbaddr", 64'(bus.readburst_address), 64'd0);
    bus.dcacheread_do = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_read(32'h0000100E, 4'd8, 1'b0, 1'b0, "post_rst");
    do_read(32'hFFFFFFFC, 4'd8, 1'b0, 1'b0, "post_rst_wrap");
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 9);
      if (n == 0) invalidate();
      if (n == 1) begin
        a = ($urandom & 32'h3FC) | (($urandom & 1) != 0 ? 32'h1000 : 32'h0);
        mem[a] = $urandom;
      end
      a = ($urandom & 32'h3FF) | (($urandom & 1) != 0 ? 32'h1000 : 32'h0);
      do_read(a, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'b0, "rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcacheread_responder.md
# dcacheread_responder

Responder end of the data-cache read link: accepts a held read request (`dcacheread_do`, length, cache-disable, address), serves it from a small direct-mapped line cache or by line bursts from memory, and returns right-aligned read data with a one-cycle `dcacheread_done` pulse. It sits directly behind the dcacheread link stage, in the memory unit between the execute-side read path and the memory burst interface.

## Interface
- `LINES`, 16, number of 16-byte cache lines; power of two, 2..256; index = addr[4+log2(LINES)-1:4], tag = addr[31:4+log2(LINES)].
- `clk`  input  1  clock.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `dcacheread_do`  input  1  request valid; held by the requester until `dcacheread_done`.
- `dcacheread_done`  output  1  one-cycle completion pulse.
- `dcacheread_length`  input  4  bytes to read, 1..8.
- `dcacheread_cache_disable`  input  1  bypass the cache, no allocation.
- `dcacheread_address`  input  32  byte address, any alignment.
- `dcacheread_data`  output  64  read data, valid only while `dcacheread_done` is high.
- `dcache_invalidate`  input  1  pulse: clear all valid bits.
- `readburst_do`  output  1  memory burst request; held until `readburst_done`.
- `readburst_address`  output  32  line-aligned address (bits [3:0] = 0).
- `readburst_data_valid`  input  1  one dword beat.
- `readburst_data`  input  32  beat data; beats arrive in ascending dword order, exactly 4 per burst.
- `readburst_done`  input  1  burst complete; coincides with or follows the 4th beat.

## Operation
- States: IDLE, LOOKUP, FILL, DONE.
- IDLE: if `dcacheread_do`, latch address, length, cache_disable; clear line counter; go LOOKUP. Request inputs are ignored in every other state.
- Access spans one line if addr[3:0] + length <= 16, else two (second line = first + 16, 32-bit wraparound: 0xFFFFFFF8 + 16 wraps to 0x00000008's line).
- LOOKUP: for current line, hit = valid[index] && tag match && !cache_disable. Hit: copy needed bytes into assembly register; if more lines, advance line and stay LOOKUP, else DONE. Miss: go FILL.
- FILL: assert `readburst_do` with line address; store beats into dword 0..3 of a line buffer. On `readburst_done`: if !cache_disable, write line into data array, set tag and valid; copy needed bytes from line buffer; next line -> LOOKUP, else DONE.
- DONE: `dcacheread_done` = 1 for exactly one cycle, `dcacheread_data` = assembly register; go IDLE.
- Data assembly: byte at request address in data[7:0], ascending; bytes at positions >= length are zero. Length 0 -> all-zero data, no lookup miss/fill (LOOKUP -> DONE). Length > 8 treated as 8.
- `dcache_invalidate`: clears all valid bits at the next edge, in any state. During FILL the line still serves the current request but is left invalid if invalidate arrives in the same cycle as or before `readburst_done`.
- cache_disable: every line fetched by burst; array contents untouched.

## Timing
- Reset values: state IDLE, all valid bits 0, `dcacheread_done` 0, `dcacheread_data` 0, `readburst_do` 0, `readburst_address` 0.
- Single-line hit: request seen in IDLE at edge N; LOOKUP cycle N+1; done high cycle N+2. Two-line hit: done at N+3.
- Miss: `readburst_do` rises cycle after LOOKUP; DONE cycle after `readburst_done` if last line.
- `dcacheread_do` remains high during the DONE cycle; it is not re-accepted until IDLE (earliest new request acceptance: cycle after done).
- `readburst_do` drops the cycle after `readburst_done`; never reasserted for the same line.
- Reset mid-burst: abandons burst immediately, no done pulse; memory side is reset by the same `rst_n`.

## Test plan
- Cold read addr 0x00001004 len 4, memory dwords 0x11111111,0x22222222,... -> one burst at 0x00001000, done with data 0x0000000022222222; repeat -> hit, done 2 cycles after acceptance, no burst.
- Read addr 0x0000100E len 8 across lines, both cold -> bursts 0x00001000 then 0x00001010, data = bytes 0x100E..0x1015 right-aligned; repeat -> hit, done at N+3.
- cache_disable=1 read of cached line after memory changed -> burst issued, new data returned; subsequent cached read returns old array data (not allocated).
- Fill line, pulse `dcache_invalidate`, re-read -> miss and burst; invalidate during FILL -> current data correct, next read misses.
- Two addresses with same index, different tag (LINES=16: 0x00000000, 0x00000100) -> second evicts first; re-reading first misses.
- Assert `rst_n`=0 mid-FILL -> `readburst_do`, `dcacheread_done` 0 immediately, all lines invalid after release.
